// File: rtl/corfifo_rd_ptr_ctrl_if.sv
// Read-side bus of the async FIFO: write-pointer input, consumer request,
// RAM read controls and registered status flags.
interface corfifo_rd_ptr_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic [ADDRWIDTH:0]   WPTR_GRAY;
    logic                 RE;
    logic                 MEM_RE;
    logic [ADDRWIDTH-1:0] MEM_RADDR;
    logic [ADDRWIDTH:0]   RPTR_GRAY;
    logic                 EMPTY;
    logic                 AEMPTY;
    logic [ADDRWIDTH:0]   RDCNT;
    logic                 DVLD;
    logic                 UNDERFLOW;

    // Read-pointer controller side
    modport slave (
        input  WPTR_GRAY, RE,
        output MEM_RE, MEM_RADDR, RPTR_GRAY, EMPTY, AEMPTY, RDCNT, DVLD, UNDERFLOW
    );

    // Consumer / write-domain side
    modport master (
        output WPTR_GRAY, RE,
        input  MEM_RE, MEM_RADDR, RPTR_GRAY, EMPTY, AEMPTY, RDCNT, DVLD, UNDERFLOW
    );
endinterface

// File: rtl/corfifo_rd_ptr_ctrl.sv
// Async FIFO read-pointer controller. Synchronizes the Gray write pointer
// into the read clock domain, owns the binary/Gray read pointer and produces
// registered occupancy and empty/almost-empty flags.
module corfifo_rd_ptr_ctrl #(
    parameter int ADDRWIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                   RCLOCK,
    input  logic                   RRESET_N,
    corfifo_rd_ptr_ctrl_if.slave   bus
);
    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    logic [PW-1:0] wsync1, wsync2;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin, rbin_next;
    logic [PW-1:0] cnt_next;
    logic          rd_acc;

    // EMPTY is registered and pessimistic, so gating with it never reads
    // an empty FIFO; during reset EMPTY=1 kills MEM_RE immediately.
    assign rd_acc        = bus.RE & ~bus.EMPTY;
    assign bus.MEM_RE    = rd_acc;
    assign bus.MEM_RADDR = rbin[ADDRWIDTH-1:0];
    assign rbin_next     = rbin + PW'(rd_acc);

    // Two-flop synchronizer; the only consumer of WPTR_GRAY
    always_ff @(posedge RCLOCK or negedge RRESET_N) begin
        if (!RRESET_N) begin
            wsync1 <= '0;
            wsync2 <= '0;
        end else begin
            wsync1 <= bus.WPTR_GRAY;
            wsync2 <= wsync1;
        end
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++)
            wbin[i] = ^(wsync2 >> i);
    end

    // Occupancy against the post-read pointer so a read costs no extra latency
    assign cnt_next = wbin - rbin_next;

    // Read pointer, its Gray image for the write domain, and status flags
    always_ff @(posedge RCLOCK or negedge RRESET_N) begin
        if (!RRESET_N) begin
            rbin          <= '0;
            bus.RPTR_GRAY <= '0;
            bus.RDCNT     <= '0;
            bus.EMPTY     <= 1'b1;
            bus.AEMPTY    <= 1'b1;
        end else begin
            rbin          <= rbin_next;
            bus.RPTR_GRAY <= rbin_next ^ (rbin_next >> 1);
            bus.RDCNT     <= cnt_next;
            bus.EMPTY     <= (cnt_next == '0);
            bus.AEMPTY    <= (cnt_next <= AE_LIM);
        end
    end

    // Data-valid tracks the one-cycle RAM read latency; underflow flags a refused read
    always_ff @(posedge RCLOCK or negedge RRESET_N) begin
        if (!RRESET_N) begin
            bus.DVLD      <= 1'b0;
            bus.UNDERFLOW <= 1'b0;
        end else begin
            bus.DVLD      <= rd_acc;
            bus.UNDERFLOW <= bus.RE & bus.EMPTY;
        end
    end
endmodule

// File: tb/tb_corfifo_rd_ptr_ctrl.sv
// Bench for corfifo_rd_ptr_ctrl (ADDRWIDTH=3, AE_THRESH=1). The model counts
// total words written and read as plain integers; the DUT's view of the write
// count lags by two sampling edges.
module tb_corfifo_rd_ptr_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    // model state
    int wp, rd_total, w1, w2, m_cnt;
    bit m_empty, m_aempty, m_dvld, m_under;

    corfifo_rd_ptr_ctrl_if #(.ADDRWIDTH(3)) bus ();

    corfifo_rd_ptr_ctrl #(.ADDRWIDTH(3), .AE_THRESH(1)) dut (
        .RCLOCK  (clk),
        .RRESET_N(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gray(input int b);
        int v;
        v = b & 15;
        return v ^ (v >> 1);
    endfunction

    // Called at a negedge; drives inputs, checks combinational outputs,
    // advances one edge, then checks registered outputs.
    task automatic step(input bit re_i, input bit wr_i);
        bit acc;
        bus.RE = re_i;
        if (wr_i) wp++;
        bus.WPTR_GRAY = 4'(gray(wp));
        #1;
        acc = re_i && !m_empty;
        chk("mem_re", int'(bus.MEM_RE), int'(acc));
        if (acc) chk("mem_raddr", int'(bus.MEM_RADDR), rd_total & 7);
        @(posedge clk);
        m_under = re_i && m_empty;
        m_dvld  = acc;
        if (acc) rd_total++;
        m_cnt    = (w2 - rd_total) & 15;
        m_empty  = (m_cnt == 0);
        m_aempty = (m_cnt <= 1);
        w2 = w1;
        w1 = wp;
        @(negedge clk);
        chk("empty", int'(bus.EMPTY), int'(m_empty));
        chk("aempty", int'(bus.AEMPTY), int'(m_aempty));
        chk("rdcnt", int'(bus.RDCNT), m_cnt);
        chk("dvld", int'(bus.DVLD), int'(m_dvld));
        chk("underflow", int'(bus.UNDERFLOW), int'(m_under));
        chk("rptr_gray", int'(bus.RPTR_GRAY), gray(rd_total));
    endtask

    // Asserts reset with RE high, checks outputs collapse at once, releases on a negedge
    task automatic do_reset();
        bus.RE = 1'b1;
        rst_n = 1'b0;
        wp = 0;
        bus.WPTR_GRAY = '0;
        #1;
        chk("rst_mem_re", int'(bus.MEM_RE), 0);
        chk("rst_empty", int'(bus.EMPTY), 1);
        chk("rst_aempty", int'(bus.AEMPTY), 1);
        chk("rst_rdcnt", int'(bus.RDCNT), 0);
        chk("rst_dvld", int'(bus.DVLD), 0);
        chk("rst_underflow", int'(bus.UNDERFLOW), 0);
        chk("rst_rptr", int'(bus.RPTR_GRAY), 0);
        rd_total = 0; w1 = 0; w2 = 0; m_cnt = 0;
        m_empty = 1; m_aempty = 1; m_dvld = 0; m_under = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.RE = 1'b0;
        bus.WPTR_GRAY = '0;
        wp = 0;
        #2;
        do_reset();

        // reads against an empty FIFO underflow and never move the pointer
        for (int i = 0; i < 4; i++) step(1, 0);
        chk("empty_rptr", int'(bus.RPTR_GRAY), 0);

        // one write shows up on the 3rd edge
        step(0, 1);
        step(0, 0);
        chk("one_wr_still_empty", int'(bus.EMPTY), 1);
        step(0, 0);
        chk("one_wr_rdcnt", int'(bus.RDCNT), 1);
        chk("one_wr_aempty", int'(bus.AEMPTY), 1);

        // write pointer stepped to 8 with RE held high; drain completely
        for (int i = 0; i < 7; i++) step(1, 1);
        for (int i = 0; i < 10; i++) step(1, 0);
        chk("burst_rptr", int'(bus.RPTR_GRAY), 4'b1100);
        chk("burst_empty", int'(bus.EMPTY), 1);

        // read accepted on the edge the new write pointer reaches the count
        step(0, 1);
        for (int i = 0; i < 3; i++) step(0, 0);
        step(0, 1);
        step(0, 0);
        step(1, 0);
        chk("coinc_rdcnt", int'(bus.RDCNT), 1);
        chk("coinc_empty", int'(bus.EMPTY), 0);
        step(1, 0);

        // move read pointer to 14, then wrap write pointer to binary 2
        for (int i = 0; i < 4; i++) step(0, 1);
        for (int i = 0; i < 2; i++) step(0, 0);
        for (int i = 0; i < 4; i++) step(1, 0);
        for (int i = 0; i < 4; i++) step(0, 1);
        for (int i = 0; i < 2; i++) step(0, 0);
        chk("wrap_rdcnt", int'(bus.RDCNT), 4);
        for (int i = 0; i < 4; i++) step(1, 0);
        chk("wrap_rptr", int'(bus.RPTR_GRAY), 4'b0011);

        // fill to full, partly drain, then reset mid-burst
        for (int i = 0; i < 8; i++) step(0, 1);
        for (int i = 0; i < 2; i++) step(0, 0);
        chk("full_rdcnt", int'(bus.RDCNT), 8);
        chk("full_empty", int'(bus.EMPTY), 0);
        chk("full_aempty", int'(bus.AEMPTY), 0);
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("pre_rst_rdcnt", int'(bus.RDCNT), 5);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0);

        // random traffic; the writer never exceeds the true depth
        for (int i = 0; i < 400; i++) begin
            bit wr;
            wr = ((wp - rd_total) < 8) && ($urandom_range(1, 0) == 1);
            step($urandom_range(1, 0) == 1, wr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
